tiny_rv_exec_muldiv: RTL and testbench
======================================

Name: tiny_rv_exec_muldiv

Overview:
Iterative RV32M multiply/divide execution unit. It sits beside the single-cycle execute ALU in the exec stage. It takes one operation per handshake, iterates BITS_PER_CYCLE bits per clock, and returns a tagged result through a valid/ready handshake. The datapath width is parametrised so the same unit can serve an RV64 variant.

Parameters:
XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC cycle; legal values 1, 2, 4.
TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  reset, asynchronous, active-low.
i_valid  in  1  upstream offers an op.
o_ready  out  1  unit can accept; high only in IDLE.
i_funct3  in  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
i_rs1  in  XLEN  operand A.
i_rs2  in  XLEN  operand B.
i_tag  in  TAG_W  rd tag.
i_flush  in  1  kill any in-flight op.
o_valid  out  1  result available.
i_ready  in  1  downstream accepts the result.
o_result  out  XLEN  result.
o_tag  out  TAG_W  tag of the result.
o_busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, sync release): state = IDLE; o_valid = 0; o_result = 0; o_tag = 0; o_busy = 0; o_ready = 1 after reset release.
- States and transitions:
  - IDLE -> CALC on accept (i_valid && o_ready && !i_flush).
  - IDLE -> DONE on accept of a special case.
  - CALC -> DONE after N = XLEN/BITS_PER_CYCLE iteration edges.
  - DONE -> IDLE on i_ready.
- Accept edge latches funct3, tag, operand magnitudes, and the result-sign flag. Signedness per operand:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL, MULHU, DIVU, REMU: both operands unsigned.
- Multiply: shift-add on magnitudes into a 2*XLEN-bit product. The final edge applies two's-complement negation when signs differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
- Special cases go IDLE -> DONE in 1 cycle:
  - Divide by zero (rs2 == 0): DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (DIV/REM, rs1 = 2^(XLEN-1) with sign bit set, rs2 = all ones): DIV -> rs1; REM -> 0.
- Latency: o_valid rises exactly N edges after the accept edge (N = 32 at defaults), or 1 edge for special cases.
- DONE handshake: o_valid, o_result, and o_tag are held stable until i_ready is sampled high. The unit returns to IDLE on that edge, so o_ready is high on the next cycle. No accept is possible in the same cycle as the result handshake; maximum throughput is one op per N+2 cycles.
- Flush: i_flush high in any state forces IDLE on the next edge and clears o_valid; the result is discarded. Flush in IDLE with i_valid high: flush wins and the op is not accepted. Flush in DONE together with i_ready counts as a flush, with no handshake.
- Inputs are ignored outside IDLE. The operand registers are not required to track the input ports.
- The iteration counter is log2(N)+1 bits and wraps only through the return to IDLE.

Decomposition:
- Shared package tiny_rv_pkg holds:
  - the funct3 localparams for M-extension ops;
  - the state enum typedef (IDLE, CALC, DONE);
  - the XLEN default.
- One sub-module, tiny_rv_muldiv_step: combinational single-bit step (conditional add for multiply, trial-subtract for divide). It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- MUL rs1 = 7, rs2 = -3 (0xFFFFFFFD) -> o_result 0xFFFFFFEB, o_valid exactly 32 cycles after accept, o_tag echoes i_tag.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV x / 0 -> 0xFFFFFFFF and REM x / 0 -> x, both in 1 cycle; DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0, both in 1 cycle.
- Back-pressure: hold i_ready = 0 for 10 cycles in DONE -> o_valid/o_result stable, o_ready = 0; release -> o_ready = 1 on the next cycle.
- Flush at CALC cycle 5, and async reset asserted mid-CALC -> IDLE, o_valid = 0, no result emitted. A following DIVU 9 / 3 returns 3 correctly.
- Regression with BITS_PER_CYCLE = 4 -> same results, latency 8.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// Shared definitions for the tiny_rv execute-stage blocks: M-extension funct3
// encodings, the mul/div sequencer states and the default datapath width.
package tiny_rv_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Signedness of each operand, as RV32M defines it per funct3.
   function automatic logic f3_rs1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_rs2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/tiny_rv_muldiv_step.sv
// One retired bit of the iterative unit: shift-add for multiply, restoring
// trial-subtract for divide, both on the shared {hi, lo} register pair.
module tiny_rv_muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi_nxt_c,
   output logic [XLEN-1:0] lo_nxt_c
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] addend;

   always_comb begin
      addend    = lo[0] ? b : {XLEN{1'b0}};
      sum       = {1'b0, hi} + {1'b0, addend};
      rem_shift = {hi, lo[XLEN-1]};
      diff      = rem_shift - {1'b0, b};
      hi_nxt_c  = hi;
      lo_nxt_c  = lo;
      if (is_div) begin
         // Borrow out of the trial subtract means restore and shift in a 0.
         if (diff[XLEN]) begin
            hi_nxt_c = rem_shift[XLEN-1:0];
            lo_nxt_c = {lo[XLEN-2:0], 1'b0};
         end else begin
            hi_nxt_c = diff[XLEN-1:0];
            lo_nxt_c = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_nxt_c = sum[XLEN:1];
         lo_nxt_c = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/tiny_rv_exec_muldiv.sv
// Iterative RV32M multiply/divide unit: operates on operand magnitudes,
// retires BITS_PER_CYCLE bits per clock and fixes up signs on the last edge.
module tiny_rv_exec_muldiv
   import tiny_rv_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEF,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned TAG_W          = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_funct3,
   input  logic [XLEN-1:0]  i_rs1,
   input  logic [XLEN-1:0]  i_rs2,
   input  logic [TAG_W-1:0] i_tag,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_result,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_busy
);

   localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = $clog2(N) + 1;

   state_e             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [2:0]         f3_q, f3_n;
   logic               neg_q, neg_n;
   logic [XLEN-1:0]    b_q, b_n;
   logic [XLEN-1:0]    hi_q, hi_n;
   logic [XLEN-1:0]    lo_q, lo_n;
   logic [TAG_W-1:0]   tag_n;
   logic [XLEN-1:0]    result_n;
   logic               valid_n;
   logic               ready_n;
   logic               busy_n;

   logic               a_sgn, b_sgn;
   logic [XLEN-1:0]    a_mag, b_mag;
   logic               div_zero, div_ovf, special;
   logic [XLEN-1:0]    special_res;
   logic [2*XLEN-1:0]  prod, prod_fix;
   logic [XLEN-1:0]    div_val;
   logic [XLEN-1:0]    final_res;

   logic [XLEN-1:0]    hi_chain [BITS_PER_CYCLE+1];
   logic [XLEN-1:0]    lo_chain [BITS_PER_CYCLE+1];

   assign hi_chain[0] = hi_q;
   assign lo_chain[0] = lo_q;

   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      tiny_rv_muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div   (f3_q[2]),
         .hi       (hi_chain[g]),
         .lo       (lo_chain[g]),
         .b        (b_q),
         .hi_nxt_c (hi_chain[g+1]),
         .lo_nxt_c (lo_chain[g+1])
      );
   end

   // Operand decode on the accept cycle: magnitudes, sign fix-up flag, shortcuts.
   always_comb begin
      a_sgn    = f3_rs1_signed(i_funct3) && i_rs1[XLEN-1];
      b_sgn    = f3_rs2_signed(i_funct3) && i_rs2[XLEN-1];
      a_mag    = a_sgn ? (-i_rs1) : i_rs1;
      b_mag    = b_sgn ? (-i_rs2) : i_rs2;
      div_zero = i_funct3[2] && (i_rs2 == {XLEN{1'b0}});
      div_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                 (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == {XLEN{1'b1}});
      special  = div_zero || div_ovf;
      if (div_zero) begin
         special_res = i_funct3[1] ? i_rs1 : {XLEN{1'b1}};
      end else begin
         special_res = i_funct3[1] ? {XLEN{1'b0}} : i_rs1;
      end
   end

   // Result as it stands after the final iteration, with the sign applied.
   always_comb begin
      prod     = {hi_chain[BITS_PER_CYCLE], lo_chain[BITS_PER_CYCLE]};
      prod_fix = neg_q ? (-prod) : prod;
      div_val  = f3_q[1] ? hi_chain[BITS_PER_CYCLE] : lo_chain[BITS_PER_CYCLE];
      if (f3_q[2]) begin
         final_res = neg_q ? (-div_val) : div_val;
      end else if (f3_q == F3_MUL) begin
         final_res = prod_fix[XLEN-1:0];
      end else begin
         final_res = prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      f3_n     = f3_q;
      neg_n    = neg_q;
      b_n      = b_q;
      hi_n     = hi_q;
      lo_n     = lo_q;
      tag_n    = o_tag;
      result_n = o_result;
      valid_n  = o_valid;
      unique case (state)
         IDLE: begin
            if (i_valid && o_ready && !i_flush) begin
               f3_n  = i_funct3;
               tag_n = i_tag;
               b_n   = b_mag;
               // Remainder follows the dividend; everything else the product sign.
               neg_n = (i_funct3 == F3_REM) ? a_sgn : (a_sgn ^ b_sgn);
               hi_n  = {XLEN{1'b0}};
               lo_n  = a_mag;
               cnt_n = {CNT_W{1'b0}};
               if (special) begin
                  state_n  = DONE;
                  valid_n  = 1'b1;
                  result_n = special_res;
               end else begin
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            hi_n  = hi_chain[BITS_PER_CYCLE];
            lo_n  = lo_chain[BITS_PER_CYCLE];
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(N - 1)) begin
               state_n  = DONE;
               valid_n  = 1'b1;
               result_n = final_res;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_n = IDLE;
               valid_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase
      if (i_flush) begin
         state_n = IDLE;
         valid_n = 1'b0;
      end
      ready_n = (state_n == IDLE);
      busy_n  = (state_n != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         o_tag    <= '0;
         o_result <= '0;
         o_valid  <= 1'b0;
         o_ready  <= 1'b1;
         o_busy   <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         f3_q     <= f3_n;
         neg_q    <= neg_n;
         b_q      <= b_n;
         hi_q     <= hi_n;
         lo_q     <= lo_n;
         o_tag    <= tag_n;
         o_result <= result_n;
         o_valid  <= valid_n;
         o_ready  <= ready_n;
         o_busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_tiny_rv_exec_muldiv.sv
// Bench for tiny_rv_exec_muldiv: directed and random ops on a 1-bit and a
// 4-bit-per-cycle instance, compared with a plain-arithmetic RV32M model.
module tb_tiny_rv_exec_muldiv;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        flush;
   logic        ready;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic [4:0]  tag;
   int          sel;

   logic        ready1, valid1, busy1;
   logic [31:0] result1;
   logic [4:0]  tag1;
   logic        ready4, valid4, busy4;
   logic [31:0] result4;
   logic [4:0]  tag4;

   logic        ready_obs, valid_obs, busy_obs;
   logic [31:0] result_obs;
   logic [4:0]  tag_obs;

   int checks;
   int failures;

   tiny_rv_exec_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid && (sel == 0)), .o_ready(ready1),
      .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2), .i_tag(tag), .i_flush(flush),
      .o_valid(valid1), .i_ready(ready), .o_result(result1), .o_tag(tag1), .o_busy(busy1)
   );

   tiny_rv_exec_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid && (sel == 1)), .o_ready(ready4),
      .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2), .i_tag(tag), .i_flush(flush),
      .o_valid(valid4), .i_ready(ready), .o_result(result4), .o_tag(tag4), .o_busy(busy4)
   );

   assign ready_obs  = (sel == 1) ? ready4  : ready1;
   assign valid_obs  = (sel == 1) ? valid4  : valid1;
   assign busy_obs   = (sel == 1) ? busy4   : busy1;
   assign result_obs = (sel == 1) ? result4 : result1;
   assign tag_obs    = (sel == 1) ? tag4    : tag1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // RV32M semantics straight from the ISA definition.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      p  = '0;
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'b100: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'b101: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'b110: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3 < 3'd4) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return (f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      @(posedge clk); #1;
      valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; tag = t;
      @(posedge clk); #1;
      valid = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag = 5'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (valid_obs !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // One full transaction with latency, result, tag and handshake checks.
   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int lat, exp_lat;
      logic [4:0] t;
      t = 5'($urandom);
      exp_lat = is_special(f3, a, b) ? 0 : ((sel == 1) ? 8 : 32);
      checks++;
      if (ready_obs !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_before: got %b want 1", name, ready_obs);
      end
      start_op(f3, a, b, t);
      checks++;
      if (busy_obs !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_after_accept: got %b want 1", name, busy_obs);
      end
      wait_valid(lat);
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (result_obs !== exp) begin
         failures++;
         $display("FAIL %s result: got %h want %h (f3=%0d a=%h b=%h)", name, result_obs, exp, f3, a, b);
      end
      checks++;
      if (tag_obs !== t) begin
         failures++;
         $display("FAIL %s tag: got %h want %h", name, tag_obs, t);
      end
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      checks++;
      if (valid_obs !== 1'b0 || ready_obs !== 1'b1) begin
         failures++;
         $display("FAIL %s handshake: valid=%b ready=%b want valid=0 ready=1", name, valid_obs, ready_obs);
      end
   endtask

   task automatic test_reset();
      sel = 0;
      rst_n = 1'b0;
      #7;
      checks++;
      if (valid1 !== 1'b0 || result1 !== 32'd0 || tag1 !== 5'd0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b result=%h tag=%h busy=%b want 0s", valid1, result1, tag1, busy1);
      end
      checks++;
      if (valid4 !== 1'b0 || result4 !== 32'd0 || tag4 !== 5'd0 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs_bpc4: valid=%b result=%h tag=%h busy=%b want 0s", valid4, result4, tag4, busy4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready1 !== 1'b1 || ready4 !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b/%b want 1/1", ready1, ready4);
      end
   endtask

   task automatic test_directed();
      do_op("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      do_op("mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
      do_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op("mulhsu_m1",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
      do_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
      do_op("divu_100_7",   3'b101, 32'd100,        32'd7,         32'd14);
      do_op("remu_100_7",   3'b111, 32'd100,        32'd7,         32'd2);
      do_op("div_by_zero",  3'b100, 32'd1234,       32'd0,         32'hFFFF_FFFF);
      do_op("rem_by_zero",  3'b110, 32'd1234,       32'd0,         32'd1234);
      do_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
      do_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
   endtask

   task automatic test_random(input int count);
      logic [2:0] f3;
      logic [31:0] a, b;
      int r;
      for (int i = 0; i < count; i++) begin
         f3 = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         r  = $urandom_range(0, 15);
         if (r == 0) b = 32'd0;
         else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (r < 5) b = $urandom_range(1, 20);
         else if (r == 5) b = -32'($urandom_range(1, 20));
         do_op("random", f3, a, b, ref_model(f3, a, b));
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0] exp;
      exp = 32'hFFFF_FFEB;
      sel = 0;
      start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (valid_obs !== 1'b1 || result_obs !== exp || tag_obs !== 5'd9 || ready_obs !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold[%0d]: valid=%b result=%h tag=%h ready=%b", i, valid_obs, result_obs, tag_obs, ready_obs);
         end
         @(posedge clk); #1;
      end
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      checks++;
      if (ready_obs !== 1'b1 || valid_obs !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: ready=%b valid=%b want 1/0", ready_obs, valid_obs);
      end
   endtask

   // Any o_valid after a kill would be a leaked result.
   task automatic expect_silence(input string name, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (valid_obs === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL %s silence: got valid=1 want no result", name);
      end
   endtask

   task automatic test_flush();
      int lat;
      sel = 0;
      start_op(3'b101, 32'd1000, 32'd7, 5'd3);
      repeat (4) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (valid_obs !== 1'b0 || ready_obs !== 1'b1 || busy_obs !== 1'b0) begin
         failures++;
         $display("FAIL flush_calc: valid=%b ready=%b busy=%b want 0/1/0", valid_obs, ready_obs, busy_obs);
      end
      expect_silence("flush_calc", 40);
      @(posedge clk); #1;
      valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
      @(posedge clk); #1;
      valid = 1'b0; flush = 1'b0;
      checks++;
      if (ready_obs !== 1'b1 || busy_obs !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle: ready=%b busy=%b want 1/0", ready_obs, busy_obs);
      end
      start_op(3'b000, 32'd5, 32'd6, 5'd1);
      wait_valid(lat);
      ready = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0; flush = 1'b0;
      checks++;
      if (valid_obs !== 1'b0 || ready_obs !== 1'b1) begin
         failures++;
         $display("FAIL flush_done: valid=%b ready=%b want 0/1", valid_obs, ready_obs);
      end
      do_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3);
   endtask

   task automatic test_reset_mid_calc();
      sel = 0;
      start_op(3'b100, 32'hFFFF_0000, 32'd13, 5'd7);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (valid_obs !== 1'b0 || busy_obs !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_calc: valid=%b busy=%b want 0/0", valid_obs, busy_obs);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready_obs !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_calc_ready: got %b want 1", ready_obs);
      end
      expect_silence("reset_mid_calc", 40);
      do_op("divu_after_reset", 3'b101, 32'd9, 32'd3, 32'd3);
   endtask

   task automatic test_back_to_back();
      sel = 0;
      for (int i = 0; i < 3; i++) begin
         do_op("b2b_mulhu", 3'b011, 32'hDEAD_BEEF + 32'(i), 32'h1234_5678, ref_model(3'b011, 32'hDEAD_BEEF + 32'(i), 32'h1234_5678));
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      valid = 1'b0; flush = 1'b0; ready = 1'b0;
      funct3 = 3'b000; rs1 = '0; rs2 = '0; tag = '0;
      sel = 0;
      rst_n = 1'b0;
      test_reset();
      sel = 0;
      test_directed();
      test_random(40);
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid_calc();
      sel = 1;
      test_directed();
      test_random(40);
      sel = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
